// File: rtl/four_to_one_tdm_mux_pkg.sv
// Shared definitions for the 4-to-1 TDM mux and its matching 1-to-4 demux:
// channel select codes, channel count and FSM state encoding.
package four_to_one_tdm_mux_pkg;

  localparam int NUM_CH = 4;

  // Select codes carried on out_sel; the downstream demux steers on these.
  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/four_to_one_tdm_mux_rr_arbiter.sv
// rr_arbiter_4: purely combinational round-robin pick of the first set
// request in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_arbiter_4
  import four_to_one_tdm_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        ptr,
  output logic              gnt_valid,
  output logic [1:0]        gnt_idx
);

  logic [1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned infers a latch.
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    idx       = ptr;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/four_to_one_tdm_mux.sv
// four_to_one_tdm_mux: four one-entry holding registers drained round-robin
// into a single registered output word tagged with its channel code.
module four_to_one_tdm_mux
  import four_to_one_tdm_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data0,
  input  logic [WIDTH-1:0]  in_data1,
  input  logic [WIDTH-1:0]  in_data2,
  input  logic [WIDTH-1:0]  in_data3,
  input  logic [NUM_CH-1:0] in_valid,
  output logic [NUM_CH-1:0] in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [1:0]        out_sel,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t            state, state_next;
  logic [1:0]        ptr;
  logic [NUM_CH-1:0] hold_full;
  logic [WIDTH-1:0]  hold_data [NUM_CH];
  logic [WIDTH-1:0]  in_data   [NUM_CH];
  logic              out_free;
  logic              gnt_valid;
  logic [1:0]        gnt_idx;
  logic              grant;

  assign in_data[0] = in_data0;
  assign in_data[1] = in_data1;
  assign in_data[2] = in_data2;
  assign in_data[3] = in_data3;

  // A granted channel is still full this cycle, so in_ready stays low and
  // the slot cannot be refilled in the same cycle it is drained.
  assign in_ready  = ~hold_full;
  assign out_valid = (state == SEND);
  assign out_free  = !out_valid || out_ready;
  assign grant     = out_free && gnt_valid;

  rr_arbiter_4 u_arb (
    .req       (hold_full),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Holding-register occupancy: set on input handshake, cleared on grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      hold_full <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant && (gnt_idx == 2'(i))) begin
          hold_full[i] <= 1'b0;
        end else if (in_valid[i] && !hold_full[i]) begin
          hold_full[i] <= 1'b1;
        end
      end
    end
  end

  // Holding-register payload captured on input handshake.
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; hold_full alone decides whether a
    // word is live, so reset only needs to clear the flags.
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_valid[i] && !hold_full[i]) begin
        hold_data[i] <= in_data[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: SEND while a word is loaded or still waiting for out_ready.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (grant) state_next = SEND;
      SEND: begin
        if (out_ready) begin
          state_next = grant ? SEND : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output word, channel tag and round-robin pointer update on grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_sel  <= CH_A;
      ptr      <= 2'd0;
    end else if (grant) begin
      out_data <= hold_data[gnt_idx];
      out_sel  <= gnt_idx;
      ptr      <= gnt_idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_four_to_one_tdm_mux.sv
// Self-checking bench for four_to_one_tdm_mux: directed vector table plus
// hand-written reset-mid-transfer and demux loopback sequences.
module tb_four_to_one_tdm_mux;
  import four_to_one_tdm_mux_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data0 = '0, in_data1 = '0, in_data2 = '0, in_data3 = '0;
  logic [3:0] in_valid = '0;
  logic [3:0] in_ready;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic       out_valid;
  logic       out_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  four_to_one_tdm_mux #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_before;
    logic [3:0] iv;
    logic [7:0] d0, d1, d2, d3;
    logic       ordy;
    logic       e_ov;
    logic [1:0] e_sel;
    logic [7:0] e_data;
    logic [3:0] e_ir;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic rb, input logic [3:0] iv,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3,
                              input logic ordy, input logic e_ov,
                              input logic [1:0] e_sel, input logic [7:0] e_data,
                              input logic [3:0] e_ir);
    vec_t v;
    v.rst_before = rb; v.iv = iv;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
    v.ordy = ordy; v.e_ov = e_ov; v.e_sel = e_sel; v.e_data = e_data; v.e_ir = e_ir;
    return v;
  endfunction

  initial begin
    logic [7:0] lb_words [4];
    logic [3:0] seen;
    int         got;

    // Single word on channel 1, then return to IDLE.
    vecs.push_back(mk(1, 4'b0010, 8'h00, 8'hA5, 8'h00, 8'h00, 1, 0, 2'd0, 8'h00, 4'b1101));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 2'd1, 8'hA5, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 2'd0, 8'h00, 4'b1111));
    // Fairness: all channels offered every cycle, refilled whenever ready.
    vecs.push_back(mk(1, 4'b1111, 8'h10, 8'h21, 8'h32, 8'h43, 1, 0, 2'd0, 8'h00, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, 8'h10, 8'h21, 8'h32, 8'h43, 1, 1, 2'd0, 8'h10, 4'b0001));
    vecs.push_back(mk(0, 4'b1111, 8'h10, 8'h21, 8'h32, 8'h43, 1, 1, 2'd1, 8'h21, 4'b0010));
    vecs.push_back(mk(0, 4'b1111, 8'h10, 8'h21, 8'h32, 8'h43, 1, 1, 2'd2, 8'h32, 4'b0100));
    vecs.push_back(mk(0, 4'b1111, 8'h10, 8'h21, 8'h32, 8'h43, 1, 1, 2'd3, 8'h43, 4'b1000));
    vecs.push_back(mk(0, 4'b1111, 8'h10, 8'h21, 8'h32, 8'h43, 1, 1, 2'd0, 8'h10, 4'b0001));
    vecs.push_back(mk(0, 4'b1111, 8'h10, 8'h21, 8'h32, 8'h43, 1, 1, 2'd1, 8'h21, 4'b0010));
    // Backpressure: 4 held + 1 output word, stable output, then RR drain.
    vecs.push_back(mk(1, 4'b1111, 8'h10, 8'h21, 8'h32, 8'h43, 0, 0, 2'd0, 8'h00, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, 8'h10, 8'h21, 8'h32, 8'h43, 0, 1, 2'd0, 8'h10, 4'b0001));
    vecs.push_back(mk(0, 4'b1111, 8'h50, 8'h21, 8'h32, 8'h43, 0, 1, 2'd0, 8'h10, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 2'd0, 8'h10, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 2'd0, 8'h10, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 2'd1, 8'h21, 4'b0010));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 2'd2, 8'h32, 4'b0110));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 2'd3, 8'h43, 4'b1110));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 2'd0, 8'h50, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 2'd0, 8'h00, 4'b1111));
    // Pointer wrap: grant channel 3, then channels 0 and 2 follow as 0, 2.
    vecs.push_back(mk(1, 4'b1000, 8'h00, 8'h00, 8'h00, 8'hC3, 1, 0, 2'd0, 8'h00, 4'b0111));
    vecs.push_back(mk(0, 4'b0101, 8'h0A, 8'h00, 8'h2A, 8'h00, 1, 1, 2'd3, 8'hC3, 4'b1010));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 2'd0, 8'h0A, 4'b1011));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 2'd2, 8'h2A, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 2'd0, 8'h00, 4'b1111));

    // Reset state.
    do_reset();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data",  32'(out_data),  32'd0);
    check("reset_out_sel",   32'(out_sel),   32'd0);
    check("reset_in_ready",  32'(in_ready),  32'hF);

    // Vector table.
    foreach (vecs[r]) begin
      if (vecs[r].rst_before) do_reset();
      in_valid  = vecs[r].iv;
      in_data0  = vecs[r].d0;
      in_data1  = vecs[r].d1;
      in_data2  = vecs[r].d2;
      in_data3  = vecs[r].d3;
      out_ready = vecs[r].ordy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", r), 32'(out_valid), 32'(vecs[r].e_ov));
      check($sformatf("vec%0d_in_ready", r),  32'(in_ready),  32'(vecs[r].e_ir));
      if (vecs[r].e_ov) begin
        check($sformatf("vec%0d_out_sel", r),  32'(out_sel),  32'(vecs[r].e_sel));
        check($sformatf("vec%0d_out_data", r), 32'(out_data), 32'(vecs[r].e_data));
      end
    end
    in_valid = '0;

    // Reset asserted mid-transfer: outputs clear without waiting for an edge.
    do_reset();
    out_ready = 1'b0;
    in_data0  = 8'h5A;
    in_data2  = 8'h7C;
    in_valid  = 4'b0101;
    @(posedge clk);
    #1;
    in_valid = '0;
    got = 0;
    for (int c = 0; c < 10 && !out_valid; c++) begin
      @(posedge clk);
      #1;
      got++;
    end
    check("midrst_reached_send", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_sel",   32'(out_sel),   32'd0);
    check("midrst_out_data",  32'(out_data),  32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'hF);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("midrst_no_stale%0d", c), 32'(out_valid), 32'd0);
    end

    // Loopback into a 1-to-4 demux model: each word must land on its channel.
    do_reset();
    lb_words[CH_A] = 8'hA0;
    lb_words[CH_B] = 8'hB1;
    lb_words[CH_C] = 8'hC2;
    lb_words[CH_D] = 8'hD3;
    in_data0  = lb_words[CH_A];
    in_data1  = lb_words[CH_B];
    in_data2  = lb_words[CH_C];
    in_data3  = lb_words[CH_D];
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = '0;
    seen     = '0;
    for (int c = 0; c < 12 && seen != 4'b1111; c++) begin
      @(posedge clk);
      #1;
      if (out_valid && out_ready) begin
        check($sformatf("loop_dup_ch%0d", out_sel), 32'(seen[out_sel]), 32'd0);
        check($sformatf("loop_ch%0d_data", out_sel), 32'(out_data), 32'(lb_words[out_sel]));
        seen[out_sel] = 1'b1;
      end
    end
    check("loop_all_channels", 32'(seen), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
